// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction fetch stage.
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    localparam logic [31:0] TEXT_BASE_DEFAULT = 32'h0040_0000;
    localparam int unsigned INSTR_BYTES       = 4;

endpackage

// File: rtl/fetch_target_check.sv
// Combinational legality check of a fetch address against the text segment.
module fetch_target_check (
    input  logic [31:0] i_target,
    input  logic [31:0] i_text_base,
    input  logic [31:0] i_text_words,
    output logic        o_aligned,
    output logic        o_in_range
);

    logic [33:0] w_limit;
    logic [33:0] w_target_ext;

    // 34-bit arithmetic so a segment ending at the top of the address space never wraps.
    assign w_limit      = {2'b00, i_text_base} + {i_text_words, 2'b00};
    assign w_target_ext = {2'b00, i_target};

    assign o_aligned  = (i_target[1:0] == 2'b00);
    assign o_in_range = (i_target >= i_text_base) && (w_target_ext < w_limit);

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, drives instruction memory and registers the IF/ID payload.
module instruction_fetch
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] TEXT_BASE  = TEXT_BASE_DEFAULT,
    parameter int unsigned TEXT_WORDS = 18
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt_req,
    output logic [31:0] read_address,
    input  logic [31:0] instruction,
    output logic        fetch_valid,
    output logic [31:0] fetch_instruction,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_pc_plus4,
    output logic        halted,
    output logic        fault
);

    localparam logic [31:0] PC_STEP     = 32'(INSTR_BYTES);
    localparam logic [31:0] TEXT_WORDS_W = 32'(TEXT_WORDS);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic         r_fetch_valid;
    logic [31:0]  r_fetch_instruction;
    logic [31:0]  r_fetch_pc;
    logic [31:0]  r_fetch_pc_plus4;
    logic         r_halted;
    logic         r_fault;

    logic [31:0]  w_pc_plus4;
    logic         w_target_aligned;
    logic         w_target_in_range;
    logic         w_target_ok;
    logic         w_next_aligned;
    logic         w_next_in_range;

    assign w_pc_plus4  = r_pc + PC_STEP;
    assign w_target_ok = w_target_aligned && w_target_in_range;

    fetch_target_check u_redirect_check (
        .i_target     (redirect_target),
        .i_text_base  (TEXT_BASE),
        .i_text_words (TEXT_WORDS_W),
        .o_aligned    (w_target_aligned),
        .o_in_range   (w_target_in_range)
    );

    // Same check on the sequential successor detects running off the end of text.
    fetch_target_check u_next_check (
        .i_target     (w_pc_plus4),
        .i_text_base  (TEXT_BASE),
        .i_text_words (TEXT_WORDS_W),
        .o_aligned    (w_next_aligned),
        .o_in_range   (w_next_in_range)
    );

    // NOTE: all state uses non-blocking assignments and the asynchronous reset branch,
    // so every register (including the payload) returns to a known value immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state             <= BOOT;
            r_pc                <= TEXT_BASE;
            r_fetch_valid       <= 1'b0;
            r_fetch_instruction <= '0;
            r_fetch_pc          <= '0;
            r_fetch_pc_plus4    <= '0;
            r_halted            <= 1'b0;
            r_fault             <= 1'b0;
        end else begin
            case (r_state)
                BOOT: begin
                    r_fetch_valid <= 1'b0;
                    if (redirect_valid && !w_target_ok) begin
                        r_state <= FAULT;
                        r_fault <= 1'b1;
                    end else begin
                        r_state <= RUN;
                        if (redirect_valid) r_pc <= redirect_target;
                    end
                end

                RUN: begin
                    if (halt_req) begin
                        r_state       <= HALT;
                        r_halted      <= 1'b1;
                        r_fetch_valid <= 1'b0;
                    end else if (redirect_valid) begin
                        r_fetch_valid <= 1'b0;
                        if (w_target_ok) begin
                            r_pc <= redirect_target;
                        end else begin
                            r_state <= FAULT;
                            r_fault <= 1'b1;
                        end
                    end else if (!stall) begin
                        r_fetch_instruction <= instruction;
                        r_fetch_pc          <= r_pc;
                        r_fetch_pc_plus4    <= w_pc_plus4;
                        r_fetch_valid       <= 1'b1;
                        // The last word is still delivered; the PC parks on it.
                        if (w_next_aligned && w_next_in_range) begin
                            r_pc <= w_pc_plus4;
                        end else begin
                            r_state  <= HALT;
                            r_halted <= 1'b1;
                        end
                    end
                end

                HALT, FAULT: begin
                    r_fetch_valid <= 1'b0;
                end

                default: begin
                    r_state       <= FAULT;
                    r_fault       <= 1'b1;
                    r_fetch_valid <= 1'b0;
                end
            endcase
        end
    end

    assign read_address      = r_pc;
    assign fetch_valid       = r_fetch_valid;
    assign fetch_instruction = r_fetch_instruction;
    assign fetch_pc          = r_fetch_pc;
    assign fetch_pc_plus4    = r_fetch_pc_plus4;
    assign halted            = r_halted;
    assign fault             = r_fault;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch with a small text-segment memory model.
module tb_instruction_fetch;

    localparam logic [31:0] BASE  = 32'h0040_0000;
    localparam int unsigned WORDS = 18;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic [31:0] read_address;
    logic [31:0] instruction;
    logic        fetch_valid;
    logic [31:0] fetch_instruction;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_plus4;
    logic        halted;
    logic        fault;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [WORDS];

    instruction_fetch #(
        .TEXT_BASE  (BASE),
        .TEXT_WORDS (WORDS)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall             (stall),
        .redirect_valid    (redirect_valid),
        .redirect_target   (redirect_target),
        .halt_req          (halt_req),
        .read_address      (read_address),
        .instruction       (instruction),
        .fetch_valid       (fetch_valid),
        .fetch_instruction (fetch_instruction),
        .fetch_pc          (fetch_pc),
        .fetch_pc_plus4    (fetch_pc_plus4),
        .halted            (halted),
        .fault             (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        if (addr >= BASE && off < 32'(4 * WORDS)) return mem[off[6:2]];
        return 32'hDEAD_BEEF;
    endfunction

    always_comb instruction = mem_word(read_address);

    task automatic step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        redirect_target = '0; halt_req = 1'b0;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        redirect_target = '0; halt_req = 1'b0;
        step(); step();
        checks++; if (read_address !== BASE) begin errors++; $display("FAIL rst_addr: got %h want %h", read_address, BASE); end
        checks++; if ({fetch_valid, halted, fault} !== 3'b000) begin errors++; $display("FAIL rst_flags: got v/h/f=%b want 000", {fetch_valid, halted, fault}); end
        checks++; if ({fetch_instruction, fetch_pc, fetch_pc_plus4} !== 96'd0) begin errors++; $display("FAIL rst_payload: got %h/%h/%h want 0", fetch_instruction, fetch_pc, fetch_pc_plus4); end
        rst_n = 1'b1;
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL boot_valid: got %b want 0", fetch_valid); end
        step();
        checks++; if (fetch_valid !== 1'b0 || read_address !== BASE) begin errors++; $display("FAIL boot_exit: got v=%b addr=%h want 0/%h", fetch_valid, read_address, BASE); end
    endtask

    // Continues from test_reset: first RUN cycle, PC = 00400000.
    task automatic test_sequential();
        step();
        checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0040_0000 || fetch_instruction !== 32'h012a_4020) begin errors++; $display("FAIL seq0: got v=%b pc=%h ins=%h want 1/00400000/012a4020", fetch_valid, fetch_pc, fetch_instruction); end
        checks++; if (fetch_pc_plus4 !== 32'h0040_0004) begin errors++; $display("FAIL seq0_p4: got %h want 00400004", fetch_pc_plus4); end
        step();
        checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0040_0004 || fetch_instruction !== 32'h0232_8022) begin errors++; $display("FAIL seq1: got v=%b pc=%h ins=%h want 1/00400004/02328022", fetch_valid, fetch_pc, fetch_instruction); end
        checks++; if (fetch_pc_plus4 !== 32'h0040_0008) begin errors++; $display("FAIL seq1_p4: got %h want 00400008", fetch_pc_plus4); end
    endtask

    // Continues from test_sequential: PC = 00400008.
    task automatic test_redirect();
        checks++; if (read_address !== 32'h0040_0008) begin errors++; $display("FAIL redir_pre: got %h want 00400008", read_address); end
        redirect_valid = 1'b1; redirect_target = 32'h0040_0010;
        step();
        redirect_valid = 1'b0;
        checks++; if (fetch_valid !== 1'b0 || read_address !== 32'h0040_0010) begin errors++; $display("FAIL redir_bubble: got v=%b addr=%h want 0/00400010", fetch_valid, read_address); end
        step();
        checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0040_0010 || fetch_instruction !== mem[4]) begin errors++; $display("FAIL redir_word: got v=%b pc=%h ins=%h want 1/00400010/%h", fetch_valid, fetch_pc, fetch_instruction, mem[4]); end
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0040_0020;
        step();
        stall = 1'b0; redirect_valid = 1'b0;
        checks++; if (fetch_valid !== 1'b0 || read_address !== 32'h0040_0020) begin errors++; $display("FAIL redir_stall: got v=%b addr=%h want 0/00400020", fetch_valid, read_address); end
        step();
        checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0040_0020 || fetch_instruction !== mem[8]) begin errors++; $display("FAIL redir_stall_word: got v=%b pc=%h ins=%h want 1/00400020/%h", fetch_valid, fetch_pc, fetch_instruction, mem[8]); end
    endtask

    task automatic test_stall();
        apply_reset();
        step(); step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (read_address !== 32'h0040_0004 || fetch_valid !== 1'b1 || fetch_pc !== 32'h0040_0000 || fetch_instruction !== 32'h012a_4020) begin
                errors++; $display("FAIL stall_hold%0d: got addr=%h v=%b pc=%h ins=%h want 00400004/1/00400000/012a4020", i, read_address, fetch_valid, fetch_pc, fetch_instruction);
            end
        end
        stall = 1'b0;
        step();
        checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0040_0004 || fetch_instruction !== 32'h0232_8022 || fetch_pc_plus4 !== 32'h0040_0008) begin
            errors++; $display("FAIL stall_release: got v=%b pc=%h ins=%h p4=%h want 1/00400004/02328022/00400008", fetch_valid, fetch_pc, fetch_instruction, fetch_pc_plus4);
        end
    endtask

    task automatic test_fault();
        logic [31:0] bad [3];
        bad[0] = 32'h0040_0006; bad[1] = 32'h0040_0048; bad[2] = 32'h003F_FFFC;
        for (int t = 0; t < 3; t++) begin
            apply_reset();
            step(); step();
            redirect_valid = 1'b1; redirect_target = bad[t];
            step();
            redirect_valid = 1'b0;
            checks++; if (fault !== 1'b1 || halted !== 1'b0 || fetch_valid !== 1'b0 || read_address !== 32'h0040_0004) begin
                errors++; $display("FAIL fault_%h: got f=%b h=%b v=%b addr=%h want 1/0/0/00400004", bad[t], fault, halted, fetch_valid, read_address);
            end
            halt_req = 1'b1;
            step();
            halt_req = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h0040_0010;
            step();
            redirect_valid = 1'b0;
            checks++; if (fault !== 1'b1 || halted !== 1'b0 || fetch_valid !== 1'b0 || read_address !== 32'h0040_0004) begin
                errors++; $display("FAIL fault_sticky_%h: got f=%b h=%b v=%b addr=%h want 1/0/0/00400004", bad[t], fault, halted, fetch_valid, read_address);
            end
        end
    endtask

    task automatic test_end_of_text();
        bit seen_last = 1'b0;
        apply_reset();
        for (int c = 0; c < 40 && !seen_last; c++) begin
            step();
            if (fetch_valid) begin
                checks++; if (fetch_instruction !== mem_word(fetch_pc) || fetch_pc_plus4 !== fetch_pc + 32'd4) begin
                    errors++; $display("FAIL eot_word: pc=%h got ins=%h p4=%h want %h/%h", fetch_pc, fetch_instruction, fetch_pc_plus4, mem_word(fetch_pc), fetch_pc + 32'd4);
                end
                if (fetch_pc == 32'h0040_0044) seen_last = 1'b1;
            end
        end
        checks++; if (!seen_last) begin errors++; $display("FAIL eot_timeout: got no valid word at 00400044 want one within 40 cycles"); end
        checks++; if (read_address !== 32'h0040_0044) begin errors++; $display("FAIL eot_addr: got %h want 00400044", read_address); end
        step();
        checks++; if (halted !== 1'b1 || fault !== 1'b0 || fetch_valid !== 1'b0 || read_address !== 32'h0040_0044) begin
            errors++; $display("FAIL eot_halt: got h=%b f=%b v=%b addr=%h want 1/0/0/00400044", halted, fault, fetch_valid, read_address);
        end
        redirect_valid = 1'b1; redirect_target = 32'h0040_0000;
        step();
        redirect_valid = 1'b0;
        checks++; if (halted !== 1'b1 || read_address !== 32'h0040_0044) begin errors++; $display("FAIL eot_sticky: got h=%b addr=%h want 1/00400044", halted, read_address); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        repeat (4) step();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (read_address !== BASE || {fetch_valid, halted, fault} !== 3'b000 || {fetch_instruction, fetch_pc, fetch_pc_plus4} !== 96'd0) begin
            errors++; $display("FAIL async_rst: got addr=%h v/h/f=%b pay=%h/%h/%h want %h/000/0", read_address, {fetch_valid, halted, fault}, fetch_instruction, fetch_pc, fetch_pc_plus4, BASE);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++; if (fetch_valid !== 1'b0 || read_address !== BASE) begin errors++; $display("FAIL async_boot: got v=%b addr=%h want 0/%h", fetch_valid, read_address, BASE); end
        step();
        checks++; if (fetch_valid !== 1'b1 || fetch_pc !== BASE || fetch_instruction !== 32'h012a_4020) begin errors++; $display("FAIL async_restart: got v=%b pc=%h ins=%h want 1/%h/012a4020", fetch_valid, fetch_pc, fetch_instruction, BASE); end
    endtask

    // Continues from test_async_reset: RUN with PC = 00400004.
    task automatic test_halt_priority();
        halt_req = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0040_0010;
        step();
        halt_req = 1'b0;
        checks++; if (halted !== 1'b1 || fault !== 1'b0 || fetch_valid !== 1'b0 || read_address !== 32'h0040_0004) begin
            errors++; $display("FAIL halt_prio: got h=%b f=%b v=%b addr=%h want 1/0/0/00400004", halted, fault, fetch_valid, read_address);
        end
        step();
        redirect_valid = 1'b0;
        checks++; if (halted !== 1'b1 || read_address !== 32'h0040_0004) begin errors++; $display("FAIL halt_sticky: got h=%b addr=%h want 1/00400004", halted, read_address); end
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = 32'h2408_0000 | 32'(i);
        mem[0] = 32'h012a_4020;
        mem[1] = 32'h0232_8022;
        mem[5] = 32'h0000_0000;

        test_reset();
        test_sequential();
        test_redirect();
        test_stall();
        test_fault();
        test_end_of_text();
        test_async_reset();
        test_halt_priority();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
